// File: rtl/cmd_master_pkg.sv
// Frame constants and FSM encoding shared by both ends of the UART register-access link.
package cmd_master_pkg;

   localparam int          CMD_WE_BIT   = 7;
   localparam logic [2:0]  WR_BYTES     = 3'd5;
   localparam logic [2:0]  RD_CMD_BYTES = 3'd1;
   localparam logic [2:0]  RD_BYTES     = 3'd4;
   localparam logic [31:0] TIMEOUT_RDAT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_SEND,
      ST_TX_ARM,
      ST_TX_WAIT,
      ST_RX_WAIT,
      ST_DONE
   } cmd_state_t;

   function automatic logic [7:0] cmd_byte(input logic we, input logic [6:0] addr);
      logic [7:0] b;
      b             = {1'b0, addr};
      b[CMD_WE_BIT] = we;
      return b;
   endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Saturating inter-byte timeout counter for the read-response phase.
module cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 120000,
   parameter int TO_W           = 17
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt_reg;

   // Holds at LAST instead of wrapping so a stalled responder stays expired.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt_reg <= '0;
      end else if (en && cnt_reg != LAST) begin
         cnt_reg <= cnt_reg + TO_W'(1);
      end
   end

   assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/cmd_master.sv
// Initiator of the UART register-access protocol: serialises a request into a command
// frame and gathers the 4-byte read response, with an inter-byte timeout.
module cmd_master
   import cmd_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 120000,
   parameter int TO_W           = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [6:0]  req_addr,
   input  logic [31:0] req_wdat,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdat,
   output logic        rsp_timeout,
   output logic [7:0]  txData,
   output logic        txSend,
   input  logic        txBusy,
   input  logic [7:0]  rxData,
   input  logic        rxValid,
   output logic        rxack
);

   cmd_state_t  state_reg;
   logic [39:0] shreg_reg;
   logic [2:0]  tx_cnt_reg;
   logic [2:0]  rx_cnt_reg;
   logic        we_reg;
   logic [31:0] rdat_sh_reg;
   logic        run_reg;
   logic        to_expired;

   cmd_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TO_W          (TO_W)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    ((state_reg != ST_RX_WAIT) || rxValid),
      .en     (state_reg == ST_RX_WAIT),
      .expired(to_expired)
   );

   // Every presented byte is popped in the cycle it is seen; only RX_WAIT keeps it.
   assign rxack = rxValid & run_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         shreg_reg   <= '0;
         tx_cnt_reg  <= '0;
         rx_cnt_reg  <= '0;
         we_reg      <= 1'b0;
         rdat_sh_reg <= '0;
         run_reg     <= 1'b0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdat    <= '0;
         rsp_timeout <= 1'b0;
         txData      <= '0;
         txSend      <= 1'b0;
      end else begin
         run_reg     <= 1'b1;
         txSend      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  shreg_reg  <= {cmd_byte(req_we, req_addr), req_wdat};
                  we_reg     <= req_we;
                  tx_cnt_reg <= req_we ? WR_BYTES : RD_CMD_BYTES;
                  req_ready  <= 1'b0;
                  state_reg  <= ST_TX_SEND;
               end
            end
            ST_TX_SEND: begin
               if (!txBusy) begin
                  txData     <= shreg_reg[39:32];
                  txSend     <= 1'b1;
                  shreg_reg  <= {shreg_reg[31:0], 8'h00};
                  tx_cnt_reg <= tx_cnt_reg - 3'd1;
                  state_reg  <= ST_TX_ARM;
               end
            end
            ST_TX_ARM: begin
               state_reg <= ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
               if (!txBusy) begin
                  if (tx_cnt_reg != 3'd0) begin
                     state_reg <= ST_TX_SEND;
                  end else if (we_reg) begin
                     rsp_valid <= 1'b1;
                     state_reg <= ST_DONE;
                  end else begin
                     rx_cnt_reg <= RD_BYTES;
                     state_reg  <= ST_RX_WAIT;
                  end
               end
            end
            ST_RX_WAIT: begin
               if (rxValid) begin
                  rdat_sh_reg <= {rdat_sh_reg[23:0], rxData};
                  rx_cnt_reg  <= rx_cnt_reg - 3'd1;
                  if (rx_cnt_reg == 3'd1) begin
                     rsp_rdat  <= {rdat_sh_reg[23:0], rxData};
                     rsp_valid <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end else if (to_expired) begin
                  rsp_rdat    <= TIMEOUT_RDAT;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state_reg   <= ST_DONE;
               end
            end
            ST_DONE: begin
               // rsp_valid is high during this state; readiness follows one cycle later.
               req_ready <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_master.sv
// Randomized bench for cmd_master with behavioural uart_tx/uart_rx and responder models.
module tb_cmd_master;

   localparam int TO_CYC   = 100;
   localparam int TO_WIDTH = 8;
   localparam int BYTE_CYC = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [6:0]  req_addr = '0;
   logic [31:0] req_wdat = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdat;
   logic        rsp_timeout;
   logic [7:0]  txData;
   logic        txSend;
   logic        txBusy;
   logic [7:0]  rxData = '0;
   logic        rxValid = 1'b0;
   logic        rxack;

   cmd_master #(
      .TIMEOUT_CYCLES(TO_CYC),
      .TO_W          (TO_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdat   (req_wdat),
      .rsp_valid  (rsp_valid),
      .rsp_rdat   (rsp_rdat),
      .rsp_timeout(rsp_timeout),
      .txData     (txData),
      .txSend     (txSend),
      .txBusy     (txBusy),
      .rxData     (rxData),
      .rxValid    (rxValid),
      .rxack      (rxack)
   );

   always #5 clk = ~clk;

   int          busy_cnt = 0;
   int          wr_left = 0;
   int          rx_gap = 0;
   int          ack_cnt = 0;
   int          send_cnt = 0;
   int          tx_overlap = 0;
   int          cyc = 0;
   int          busy_fall = 0;
   logic [7:0]  tx_log[$];
   logic [7:0]  rx_q[$];
   bit          resp_on = 1'b0;
   logic [31:0] resp_word = '0;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_rdat = '0;

   assign txBusy = (busy_cnt != 0);

   // uart_tx busy timing, uart_rx level/ack handshake and the remote responder.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) busy_fall <= cyc + 1;
      end
      if (rxValid) begin
         if (rxack) begin
            rxValid <= 1'b0;
            ack_cnt <= ack_cnt + 1;
            rx_gap  <= $urandom_range(4, 30);
         end
      end else if (rx_gap != 0) begin
         rx_gap <= rx_gap - 1;
      end else if (rx_q.size() != 0) begin
         rxData  <= rx_q.pop_front();
         rxValid <= 1'b1;
      end
      if (txSend) begin
         if (busy_cnt != 0) tx_overlap <= tx_overlap + 1;
         tx_log.push_back(txData);
         send_cnt <= send_cnt + 1;
         busy_cnt <= BYTE_CYC;
         if (wr_left != 0) begin
            wr_left <= wr_left - 1;
         end else if (txData[7]) begin
            wr_left <= 4;
         end else if (resp_on) begin
            for (int k = 3; k >= 0; k--) rx_q.push_back(resp_word[8*k +: 8]);
            rx_gap <= BYTE_CYC + $urandom_range(4, 20);
         end
      end
      if (!rst) wr_left <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic send_req(input logic we, input logic [6:0] addr, input logic [31:0] wdat,
                           input string tag);
      int i;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdat  = wdat;
      for (i = 0; i < 2000 && req_ready !== 1'b1; i++) @(negedge clk);
      chk({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int i;
      for (i = 0; i < 3000 && rsp_valid !== 1'b1; i++) @(negedge clk);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic run_txn(input logic we, input logic [6:0] addr, input logic [31:0] wdat,
                          input bit resp, input logic [31:0] rword, input string tag);
      logic [7:0] exp_q[$];
      int         acks0;
      int         d;
      logic       exp_to;
      tx_log.delete();
      resp_on   = resp;
      resp_word = rword;
      acks0     = ack_cnt;
      exp_q.push_back({we, addr});
      if (we) for (int k = 3; k >= 0; k--) exp_q.push_back(wdat[8*k +: 8]);
      exp_to = 1'b0;
      if (!we) begin
         if (resp) exp_rdat = rword;
         else begin
            exp_rdat = 32'hFFFF_FFFF;
            exp_to   = 1'b1;
         end
      end
      send_req(we, addr, wdat, tag);
      wait_rsp(tag);
      d = cyc - busy_fall;
      chk({tag, "_rdat"}, rsp_rdat, exp_rdat);
      chk({tag, "_timeout"}, {31'd0, rsp_timeout}, {31'd0, exp_to});
      chk({tag, "_ntx"}, tx_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < tx_log.size(); k++)
         chk({tag, "_txbyte"}, {24'd0, tx_log[k]}, {24'd0, exp_q[k]});
      chk({tag, "_acks"}, ack_cnt - acks0, (!we && resp) ? 32'd4 : 32'd0);
      if (exp_to) chk({tag, "_to_latency_in_range"}, {31'd0, (d >= TO_CYC && d <= TO_CYC + 2)}, 32'd1);
      $display("txn %s we=%0d addr=%02h wdat=%08h -> rdat=%08h to=%0d", tag, we, addr, wdat,
               rsp_rdat, rsp_timeout);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
      resp_on = 1'b0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          a0;
      int          s0;
      int          i;
      logic [31:0] w;
      logic [7:0]  bb[$];

      repeat (4) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_txsend", {31'd0, txSend}, 32'd0);
      chk("rst_rxack", {31'd0, rxack}, 32'd0);
      chk("rst_rdat", rsp_rdat, 32'd0);
      chk("rst_timeout", {31'd0, rsp_timeout}, 32'd0);
      chk("rst_txdata", {24'd0, txData}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

      run_txn(1'b1, 7'h7F, 32'h1234_5678, 1'b1, 32'h0, "wr7f");
      run_txn(1'b0, 7'h0F, 32'h0, 1'b1, 32'h1122_3344, "rd0f");
      run_txn(1'b0, 7'h22, 32'h0, 1'b0, 32'h0, "rd_silent");
      run_txn(1'b1, 7'h05, 32'hCAFE_F00D, 1'b1, 32'h0, "wr_after_to");

      // Stray byte while idle must be popped and ignored.
      a0 = ack_cnt;
      rx_q.push_back(8'hAA);
      for (i = 0; i < 200 && ack_cnt == a0; i++) @(negedge clk);
      chk("stray_ack", ack_cnt - a0, 32'd1);
      chk("stray_idle", {31'd0, req_ready}, 32'd1);
      run_txn(1'b0, 7'h33, 32'h0, 1'b1, 32'hDEAD_C0DE, "rd_after_stray");

      for (int n = 0; n < 16; n++) begin
         run_txn(1'($urandom_range(0, 1)), 7'($urandom), $urandom, 1'b1, $urandom, "rand");
      end

      // Reset while the third byte of a write is on the line.
      s0 = send_cnt;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 7'h44;
      req_wdat  = 32'h0102_0304;
      for (i = 0; i < 2000 && send_cnt < s0 + 3; i++) begin
         @(negedge clk);
         if (req_ready === 1'b0) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      chk("mid_rst_sent3", send_cnt - s0, 32'd3);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_txsend", {31'd0, txSend}, 32'd0);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_rdat = 32'd0;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_more_tx", send_cnt - s0, 32'd3);
      chk("mid_rst_rdat_cleared", rsp_rdat, 32'd0);
      run_txn(1'b0, 7'h11, 32'h0, 1'b1, 32'h5A5A_A5A5, "rd_after_rst");

      // req_valid held high across a write completion, then a read.
      tx_log.delete();
      s0 = send_cnt;
      a0 = ack_cnt;
      w = $urandom;
      resp_on = 1'b1;
      resp_word = w;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 7'h55;
      req_wdat  = 32'h8899_AABB;
      for (i = 0; i < 2000 && req_ready !== 1'b1; i++) @(negedge clk);
      chk("b2b_wr_accept", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_we   = 1'b0;
      req_addr = 7'h66;
      wait_rsp("b2b_wr");
      chk("b2b_wr_rdat", rsp_rdat, exp_rdat);
      chk("b2b_ready_at_rsp", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_after_rsp", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_rd_taken", {31'd0, req_ready}, 32'd0);
      exp_rdat = w;
      wait_rsp("b2b_rd");
      chk("b2b_rd_rdat", rsp_rdat, exp_rdat);
      chk("b2b_sends", send_cnt - s0, 32'd6);
      chk("b2b_acks", ack_cnt - a0, 32'd4);
      bb = '{8'hD5, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'h66};
      chk("b2b_ntx", tx_log.size(), 32'd6);
      for (int k = 0; k < 6 && k < tx_log.size(); k++)
         chk("b2b_txbyte", {24'd0, tx_log[k]}, {24'd0, bb[k]});
      $display("txn b2b wr 55 then rd 66 -> rdat=%08h", rsp_rdat);
      resp_on = 1'b0;
      repeat (3) @(negedge clk);

      chk("tx_no_overlap", tx_overlap, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
